// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 2-word blocks.
// Hits resolve combinationally in IDLE; misses fill the block via two memory transfers.
module icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 32 - IDX_W - 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        inv,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL0 = 2'd1, FILL1 = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [SETS-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q   [SETS];
  logic [31:0]        data0_q [SETS];
  logic [31:0]        data1_q [SETS];
  logic [TAG_W-1:0]   ftag_q, ftag_d;
  logic [IDX_W-1:0]   fidx_q, fidx_d;
  logic [31:0]        buf0_q, buf0_d;
  logic               fill_we;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               unused_addr_bits;

  assign req_idx          = imemaddr[IDX_W+2:3];
  assign req_tag          = imemaddr[31:IDX_W+3];
  assign unused_addr_bits = ^imemaddr[1:0];
  assign dbg_state_o      = state_q;

  assign hit      = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign ihit     = hit & (state_q == IDLE) & ~inv;
  assign imemload = ihit ? (imemaddr[2] ? data1_q[req_idx] : data0_q[req_idx]) : 32'd0;

  // Memory handshake: iREN requests the word at iaddr; a transfer completes on a
  // cycle with iREN & ~iwait, when iload is captured. While iwait is high the
  // request (iREN, iaddr) is held unchanged and iload is ignored.
  always_comb begin
    state_d = state_q;
    ftag_d  = ftag_q;
    fidx_d  = fidx_q;
    buf0_d  = buf0_q;
    fill_we = 1'b0;
    iREN    = 1'b0;
    iaddr   = 32'd0;
    case (state_q)
      IDLE: begin
        if (imemREN & ~hit & ~inv) begin
          state_d = FILL0;
          ftag_d  = req_tag;
          fidx_d  = req_idx;
        end
      end
      FILL0: begin
        iREN  = 1'b1;
        iaddr = {ftag_q, fidx_q, 3'b000};
        if (inv) begin
          state_d = IDLE;
        end else if (~iwait) begin
          buf0_d  = iload;
          state_d = FILL1;
        end
      end
      FILL1: begin
        iREN  = 1'b1;
        iaddr = {ftag_q, fidx_q, 3'b100};
        // Invalidate wins over a same-cycle completion: the line is not written.
        if (inv) begin
          state_d = IDLE;
        end else if (~iwait) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      valid_q <= '0;
      ftag_q  <= '0;
      fidx_q  <= '0;
      buf0_q  <= '0;
    end else begin
      state_q <= state_d;
      ftag_q  <= ftag_d;
      fidx_q  <= fidx_d;
      buf0_q  <= buf0_d;
      if (inv) begin
        valid_q <= '0;
      end else if (fill_we) begin
        valid_q[fidx_q] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fidx_q]   <= ftag_q;
      data0_q[fidx_q] <= buf0_q;
      data1_q[fidx_q] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed corner sequences, a hit-sweep vector
// table and randomized fetches checked against a block-level cache model.
module tb_icache;

  localparam int SETS  = 16;
  localparam int IDX_W = 4;
  localparam int TAG_W = 25;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        inv;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [1:0]  dbg_state;

  icache #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .inv(inv),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .dbg_state_o(dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Memory model and responder controls
  logic [31:0] mem_ovr [logic [31:0]];
  int          lat = 0;
  bit          mem_hold = 1'b0;
  logic [31:0] xfer_q [$];

  // Cache model: which blocks are resident
  bit               m_valid [SETS];
  logic [TAG_W-1:0] m_tag   [SETS];

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        exp_hit;
    logic [31:0] exp_load;
  } vec_t;
  vec_t vecs [20];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_ovr.exists(w)) return mem_ovr[w];
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
  endtask

  // Memory responder: each transfer waits `lat` cycles, then completes.
  initial begin
    int          wcnt;
    logic [31:0] last_a;
    wcnt = 0;
    last_a = '1;
    iwait = 1'b0;
    iload = 32'd0;
    forever begin
      @(negedge CLK);
      if (mem_hold) begin
        iwait = 1'b1;
        iload = $urandom;
        wcnt  = 0;
      end else if (RST || !iREN) begin
        iwait  = 1'b0;
        iload  = $urandom;
        wcnt   = 0;
        last_a = '1;
      end else begin
        if (iaddr != last_a) begin
          wcnt   = 0;
          last_a = iaddr;
        end
        if (wcnt < lat) begin
          iwait = 1'b1;
          iload = $urandom;
          wcnt++;
        end else begin
          iwait  = 1'b0;
          iload  = mem_val(iaddr);
          wcnt   = 0;
          last_a = '1;
          xfer_q.push_back(iaddr);
        end
      end
    end
  end

  // Issue one fetch and hold it until it hits; check latency, data and transfers.
  task automatic fetch(input logic [31:0] addr);
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tg;
    bit               resident;
    int               n;
    idx = addr[IDX_W+2:3];
    tg  = addr[31:IDX_W+3];
    resident = m_valid[idx] && (m_tag[idx] == tg);
    xfer_q.delete();
    imemREN  = 1'b1;
    imemaddr = addr;
    n = 0;
    while (n < 60) begin
      @(negedge CLK);
      if (ihit) break;
      n++;
      @(posedge CLK); #1;
    end
    chk("fetch_ihit", 32'(ihit), 32'd1);
    chk("fetch_latency", n, resident ? 0 : 1 + 2 * (lat + 1));
    chk("fetch_data", imemload, mem_val(addr));
    chk("fetch_hit_no_iren", 32'(iREN), 32'd0);
    if (resident) begin
      chk("fetch_hit_xfers", xfer_q.size(), 0);
    end else begin
      chk("fetch_miss_xfers", xfer_q.size(), 2);
      if (xfer_q.size() == 2) begin
        chk("fetch_xfer0_addr", xfer_q[0], {addr[31:3], 3'b000});
        chk("fetch_xfer1_addr", xfer_q[1], {addr[31:3], 3'b100});
      end
    end
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  // One-cycle invalidate while presenting a request; ihit must be suppressed.
  task automatic pulse_inv(input logic [31:0] addr);
    imemREN  = 1'b1;
    imemaddr = addr;
    inv      = 1'b1;
    @(negedge CLK);
    chk("inv_cycle_ihit", 32'(ihit), 32'd0);
    chk("inv_cycle_load", imemload, 32'd0);
    @(posedge CLK); #1;
    inv     = 1'b0;
    imemREN = 1'b0;
    model_clear();
  endtask

  initial begin
    int n;
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; inv = 1'b0;
    model_clear();
    mem_ovr[32'h40] = 32'hAAAA_0001;
    mem_ovr[32'h44] = 32'hAAAA_0002;
    for (int s = 0; s < 16; s++) begin
      vecs[s].ren      = 1'b1;
      vecs[s].addr     = 32'(s * 8 + (s % 2) * 4);
      vecs[s].exp_hit  = 1'b1;
      vecs[s].exp_load = mem_val(32'(s * 8 + (s % 2) * 4));
    end
    for (int s = 16; s < 20; s++) begin
      vecs[s].ren      = 1'b0;
      vecs[s].addr     = 32'((s - 16) * 8);
      vecs[s].exp_hit  = 1'b0;
      vecs[s].exp_load = 32'd0;
    end

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_ihit", 32'(ihit), 32'd0);
    chk("reset_iren", 32'(iREN), 32'd0);
    chk("reset_iaddr", iaddr, 32'd0);
    chk("reset_load", imemload, 32'd0);
    @(posedge CLK); #1;

    // 1: cold miss on 0x40 with two waits per transfer, then both words hit
    lat = 2;
    fetch(32'h40);
    fetch(32'h44);

    // 2: conflict on set 8
    lat = 1;
    fetch(32'h440);
    fetch(32'h40);

    // 3: request dropped and address changed mid-fill; fill still completes
    pulse_inv(32'h40);
    mem_hold = 1'b1;
    imemREN = 1'b1; imemaddr = 32'h40;
    @(posedge CLK); #1;
    imemREN = 1'b0; imemaddr = 32'h100;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("hold_iren", 32'(iREN), 32'd1);
      chk("hold_iaddr", iaddr, 32'h40);
      chk("hold_ihit", 32'(ihit), 32'd0);
      @(posedge CLK); #1;
    end
    mem_hold = 1'b0;
    lat = 1;
    n = 0;
    while (iREN && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("squash_fill_done", 32'(iREN), 32'd0);
    m_valid[8] = 1'b1;
    m_tag[8]   = '0;
    fetch(32'h40);
    fetch(32'h100);

    // 4: invalidate in FILL1 on the completing cycle
    pulse_inv(32'h40);
    lat = 0;
    imemREN = 1'b1; imemaddr = 32'h40;
    @(posedge CLK); #1;
    imemREN = 1'b0;
    @(negedge CLK);
    chk("fill0_iaddr", iaddr, 32'h40);
    @(posedge CLK); #1;
    chk("fill1_iaddr", iaddr, 32'h44);
    inv = 1'b1;
    @(posedge CLK); #1;
    inv = 1'b0;
    model_clear();
    chk("inv_abort_iren", 32'(iREN), 32'd0);
    chk("inv_abort_iaddr", iaddr, 32'd0);
    fetch(32'h40);

    // 5: reset during FILL0
    mem_hold = 1'b1;
    imemREN = 1'b1; imemaddr = 32'h200;
    @(posedge CLK); #1;
    imemREN = 1'b0;
    @(negedge CLK);
    chk("rst_fill0_iaddr", iaddr, 32'h200);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_clear();
    @(negedge CLK);
    chk("rst_mid_iren", 32'(iREN), 32'd0);
    chk("rst_mid_iaddr", iaddr, 32'd0);
    chk("rst_mid_ihit", 32'(ihit), 32'd0);
    @(posedge CLK); #1;
    mem_hold = 1'b0;
    lat = 1;
    fetch(32'h40);

    // 6: fill all sets, then back-to-back hits from the vector table with memory busy
    lat = 0;
    for (int s = 0; s < 16; s++) fetch(32'(s * 8));
    mem_hold = 1'b1;
    for (int v = 0; v < 20; v++) begin
      imemREN  = vecs[v].ren;
      imemaddr = vecs[v].addr;
      @(negedge CLK);
      chk("vec_ihit", 32'(ihit), 32'(vecs[v].exp_hit));
      chk("vec_load", imemload, vecs[v].exp_load);
      chk("vec_iren", 32'(iREN), 32'd0);
      @(posedge CLK); #1;
    end
    imemREN  = 1'b0;
    mem_hold = 1'b0;

    // Randomized fetches over a few aliasing tags
    for (int r = 0; r < 80; r++) begin
      logic [31:0] a;
      lat = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) << (IDX_W + 3)) | ($urandom_range(0, SETS - 1) << 3)
          | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) pulse_inv(a);
      fetch(a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
